// File: rtl/ao_result_collector.sv
// Collects AO ray results from the traversal core, counts occluded samples per
// pixel in a RAM, and emits a pixel through a FWFT FIFO once all of its
// samples have arrived. Rays may arrive in any order.
//
// state | meaning
// CLEAR | zero one RAM entry per cycle, input blocked
// RUN   | accept results while FIFO room allows
// DRAIN | input blocked, wait for pipeline and FIFO to empty
// DONE  | all work drained, held until reset
module ao_result_collector #(
  parameter int          NUM_PIXELS = 1024,
  parameter int          SAMPLES    = 16,
  parameter int          OUT_DEPTH  = 8,
  parameter logic [31:0] AO_RADIUS  = 32'h3F800000,
  parameter logic [31:0] MISS_HITT  = 32'h7F800000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_in_valid,
  output logic                          io_in_ready,
  input  logic [31:0]                   io_hitT,
  input  logic [31:0]                   io_ray_id_triangle,
  input  logic                          io_rtp_finish,
  output logic                          io_out_valid,
  input  logic                          io_out_ready,
  output logic [$clog2(NUM_PIXELS)-1:0] io_out_pixel,
  output logic [$clog2(SAMPLES):0]      io_out_occ,
  output logic                          io_done,
  output logic [31:0]                   io_pixels_done,
  output logic                          io_err_range,
  output logic                          io_err_overflow
);

  localparam int PW   = $clog2(NUM_PIXELS);
  localparam int SW   = $clog2(SAMPLES);
  localparam int CW   = SW + 1;
  localparam int ID_W = PW + SW;
  localparam int FAW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int FCW  = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {CLEAR, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   clr_ptr;
  logic            clr_we;

  logic [PW-1:0]   in_pixel;
  logic            in_range;
  logic            occluded;
  logic            accept;
  logic            pipe_enter;
  logic            ready_room;
  logic [FCW:0]    load;

  logic [2*CW-1:0] ram [NUM_PIXELS];
  logic [2*CW-1:0] rd_data;
  logic [2*CW-1:0] wr_data;
  logic [PW-1:0]   wr_addr;
  logic            wr_en;

  logic            s1_valid;
  logic [PW-1:0]   s1_pixel;
  logic            s1_occluded;
  logic [2*CW-1:0] s1_data;

  logic            s2_valid;
  logic [PW-1:0]   s2_pixel;
  logic            s2_occluded;
  logic [CW-1:0]   s2_occ;
  logic [CW-1:0]   s2_cnt;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   occ_inc;
  logic [2*CW-1:0] s2_wdata;
  logic            s2_push;
  logic            s2_ovf;

  logic [PW+CW-1:0] fifo_mem [OUT_DEPTH];
  logic [FAW-1:0]   rd_ptr, wr_ptr;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_push;
  logic             fifo_pop;

  function automatic logic [FAW-1:0] ptr_inc(input logic [FAW-1:0] p);
    return (p == FAW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_pixel   = io_ray_id_triangle[ID_W-1:SW];
  assign in_range   = (io_ray_id_triangle >> ID_W) == 32'd0;
  // NaN and +inf are excluded by the magnitude compare or the miss pattern;
  // any negative value is a miss.
  assign occluded   = (io_hitT != MISS_HITT) && !io_hitT[31] &&
                      (io_hitT[30:0] < AO_RADIUS[30:0]);
  assign accept     = io_in_valid && io_in_ready;
  assign pipe_enter = accept && in_range;

  // Every in-flight entry may complete a pixel, so count them against FIFO room.
  assign load       = (FCW+1)'(fifo_count) + (FCW+1)'(s1_valid) + (FCW+1)'(s2_valid);
  assign ready_room = load <= (FCW+1)'(OUT_DEPTH - 1);
  assign io_done    = (state == DONE);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nxt;
  end

  // Next-state and per-state controls.
  always_comb begin
    state_nxt   = state;
    io_in_ready = 1'b0;
    clr_we      = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_ptr == PW'(NUM_PIXELS - 1)) state_nxt = RUN;
      end
      RUN: begin
        io_in_ready = ready_room;
        if (io_rtp_finish) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid && fifo_count == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Clear pointer walks the RAM once per CLEAR pass.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              clr_ptr <= '0;
    else if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
  end

  // RAM write port is shared between CLEAR and the S2 write-back.
  always_comb begin
    wr_en   = clr_we || s2_valid;
    wr_addr = clr_we ? clr_ptr : s2_pixel;
    wr_data = clr_we ? '0 : s2_wdata;
  end

  // Write-first RAM: a read issued while S2 writes the same entry sees the new value.
  always_ff @(posedge clock) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    rd_data <= (wr_en && wr_addr == in_pixel) ? wr_data : ram[in_pixel];
  end

  // S1: read data returns.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid    <= 1'b0;
      s1_pixel    <= '0;
      s1_occluded <= 1'b0;
    end else begin
      s1_valid <= pipe_enter;
      if (pipe_enter) begin
        s1_pixel    <= in_pixel;
        s1_occluded <= occluded;
      end
    end
  end

  // Forward the value S2 is writing when it targets the same pixel as S1.
  always_comb begin
    s1_data = rd_data;
    if (s2_valid && s2_pixel == s1_pixel) s1_data = s2_wdata;
  end

  // S2: latch the entry for update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid    <= 1'b0;
      s2_pixel    <= '0;
      s2_occluded <= 1'b0;
      s2_occ      <= '0;
      s2_cnt      <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pixel    <= s1_pixel;
        s2_occluded <= s1_occluded;
        s2_occ      <= s1_data[2*CW-1:CW];
        s2_cnt      <= s1_data[CW-1:0];
      end
    end
  end

  // S2 update: count the sample, complete and recycle the entry, or saturate.
  always_comb begin
    cnt_inc  = s2_cnt + CW'(1);
    occ_inc  = s2_occ + CW'(s2_occluded);
    s2_wdata = {occ_inc, cnt_inc};
    s2_push  = 1'b0;
    s2_ovf   = 1'b0;
    if (s2_cnt == CW'(SAMPLES)) begin
      s2_ovf   = s2_valid;
      s2_wdata = {s2_occ, s2_cnt};
    end else if (cnt_inc == CW'(SAMPLES)) begin
      s2_push  = s2_valid;
      s2_wdata = '0;
    end
  end

  assign fifo_pop     = io_out_valid && io_out_ready;
  assign fifo_push    = s2_push && ((fifo_count != FCW'(OUT_DEPTH)) || fifo_pop);
  assign io_out_valid = (fifo_count != '0);
  assign {io_out_pixel, io_out_occ} = io_out_valid ? fifo_mem[rd_ptr] : '0;

  // FIFO storage.
  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[wr_ptr] <= {s2_pixel, occ_inc};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Status: emitted-pixel counter and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_pixels_done  <= '0;
      io_err_range    <= 1'b0;
      io_err_overflow <= 1'b0;
    end else begin
      if (fifo_push)            io_pixels_done  <= io_pixels_done + 32'd1;
      if (accept && !in_range)  io_err_range    <= 1'b1;
      if (s2_ovf)               io_err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ao_result_collector.sv
// Bench for ao_result_collector: directed scenarios plus shuffled/random
// traffic, checked against a per-pixel sample-count model.
module tb_ao_result_collector;

  localparam int NPIX  = 1024;
  localparam int SAMP  = 16;
  localparam int DEPTH = 8;

  localparam logic [31:0] H_HALF = 32'h3F000000;
  localparam logic [31:0] H_QTR  = 32'h3E800000;
  localparam logic [31:0] H_TWO  = 32'h40000000;
  localparam logic [31:0] H_NEG  = 32'hBF000000;
  localparam logic [31:0] H_NAN  = 32'h7FC00000;
  localparam logic [31:0] H_MISS = 32'h7F800000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [31:0] io_hitT = '0;
  logic [31:0] io_ray_id_triangle = '0;
  logic        io_rtp_finish = 1'b0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [9:0]  io_out_pixel;
  logic [4:0]  io_out_occ;
  logic        io_done;
  logic [31:0] io_pixels_done;
  logic        io_err_range;
  logic        io_err_overflow;

  always #5 clock = ~clock;

  ao_result_collector dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_hitT            (io_hitT),
    .io_ray_id_triangle (io_ray_id_triangle),
    .io_rtp_finish      (io_rtp_finish),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_pixel       (io_out_pixel),
    .io_out_occ         (io_out_occ),
    .io_done            (io_done),
    .io_pixels_done     (io_pixels_done),
    .io_err_range       (io_err_range),
    .io_err_overflow    (io_err_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: samples seen and occluded samples per pixel, plus the
  // expected emission order.
  int m_cnt [NPIX];
  int m_occ [NPIX];
  int exp_q [$];
  int m_pushes  = 0;
  int m_accepts = 0;
  bit m_err_range = 1'b0;
  int pops    = 0;
  int max_occ = 0;
  int ids [$];

  // A hit occludes when it is a non-negative float below 1.0; positive
  // float bit patterns order the same way as their values.
  function automatic bit is_occ(input logic [31:0] h);
    return !h[31] && (h < 32'h3F800000);
  endfunction

  function automatic logic [31:0] rand_hit();
    case ($urandom_range(5, 0))
      0:       return H_HALF;
      1:       return H_MISS;
      2:       return H_TWO;
      3:       return H_NEG;
      4:       return H_NAN;
      default: return $urandom();
    endcase
  endfunction

  task automatic model_accept(input logic [31:0] id, input logic [31:0] h);
    int p;
    m_accepts++;
    if (id >= 32'(NPIX * SAMP)) begin
      m_err_range = 1'b1;
    end else begin
      p = int'(id) / SAMP;
      m_cnt[p]++;
      if (is_occ(h)) m_occ[p]++;
      if (m_cnt[p] == SAMP) begin
        exp_q.push_back(p * 256 + m_occ[p]);
        m_pushes++;
        m_cnt[p] = 0;
        m_occ[p] = 0;
      end
    end
  endtask

  // Handshakes observed mid-cycle are the ones that complete at the next edge.
  always @(negedge clock) begin
    int e;
    int occ_now;
    if (reset) begin
      occ_now = int'(io_pixels_done) - pops;
      if (occ_now > max_occ) max_occ = occ_now;
      if (io_in_valid && io_in_ready) model_accept(io_ray_id_triangle, io_hitT);
      if (io_out_valid && io_out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", {22'd0, io_out_pixel}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_pixel", {22'd0, io_out_pixel}, 32'(e / 256));
          check("out_occ", {27'd0, io_out_occ}, 32'(e % 256));
        end
      end
    end
  end

  task automatic send(input logic [31:0] id, input logic [31:0] h);
    int guard;
    guard = 0;
    io_in_valid        = 1'b1;
    io_ray_id_triangle = id;
    io_hitT            = h;
    do begin
      @(negedge clock);
      guard++;
    end while (!io_in_ready && guard < 2000);
    if (!io_in_ready) begin
      check("send_timeout", 32'(io_in_ready), 32'd1);
      io_in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      io_in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || io_out_valid) && n < 1000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(tag, 32'(n < 1000), 32'd1);
  endtask

  task automatic shuffle_ids();
    int j;
    int t;
    for (int i = ids.size() - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = ids[i];
      ids[i] = ids[j];
      ids[j] = t;
    end
  endtask

  initial begin
    int n;
    bit saw_out;
    bit stalled;
    int acc_before;

    // Reset state, then CLEAR length with valid held high.
    io_in_valid        = 1'b1;
    io_ray_id_triangle = 32'd0;
    io_hitT            = H_MISS;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(io_in_ready), 32'd0);
    check("rst_out_valid", 32'(io_out_valid), 32'd0);
    check("rst_done", 32'(io_done), 32'd0);
    check("rst_pixels_done", io_pixels_done, 32'd0);
    check("rst_err_range", 32'(io_err_range), 32'd0);
    check("rst_err_overflow", 32'(io_err_overflow), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    saw_out = 1'b0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (io_out_valid) saw_out = 1'b1;
    end while (!io_in_ready && n < 2000);
    io_in_valid = 1'b0;
    check("clear_cycles", 32'(n), 32'(NPIX));
    check("clear_no_output", 32'(saw_out), 32'd0);

    // Pixel 0 in order, alternating occluding and miss; also first-result latency.
    for (int i = 0; i < SAMP; i++) send(32'(i), (i % 2 == 0) ? H_HALF : H_MISS);
    check("lat_n1", 32'(io_out_valid), 32'd0);
    @(posedge clock); #1;
    check("lat_n2", 32'(io_out_valid), 32'd0);
    @(posedge clock); #1;
    check("lat_n3", 32'(io_out_valid), 32'd1);
    wait_drain("t2_drain");
    check("t2_pixels_done", io_pixels_done, 32'd1);

    // Pixel 2 back-to-back shuffled, exercising forwarding.
    ids.delete();
    for (int i = 33; i <= 46; i++) ids.push_back(i);
    shuffle_ids();
    ids.push_front(32);
    ids.push_front(47);
    foreach (ids[i]) send(32'(ids[i]), H_QTR);
    wait_drain("t3_drain");
    check("t3_pixels_done", io_pixels_done, 32'd2);

    // Pixel 3 with far, negative and NaN hits.
    send(32'd48, H_TWO);
    send(32'd49, H_NEG);
    send(32'd50, H_NAN);
    for (int i = 51; i <= 63; i++) send(32'(i), H_HALF);
    wait_drain("t4_drain");
    check("t4_pixels_done", io_pixels_done, 32'd3);

    // Ten pixels completing under backpressure, random order and hits.
    ids.delete();
    for (int i = 10 * SAMP; i < 20 * SAMP; i++) ids.push_back(i);
    shuffle_ids();
    io_out_ready = 1'b0;
    stalled = 1'b0;
    fork
      begin
        foreach (ids[i]) send(32'(ids[i]), rand_hit());
      end
      begin
        repeat (400) begin
          @(negedge clock);
          if (io_in_valid && !io_in_ready) stalled = 1'b1;
        end
        io_out_ready = 1'b1;
      end
    join
    wait_drain("t5_drain");
    check("t5_stalled", 32'(stalled), 32'd1);
    check("t5_fifo_bound", 32'(max_occ <= DEPTH), 32'd1);
    check("t5_pixels_done", io_pixels_done, 32'd13);

    // Out-of-range id, half-filled pixel 5, then finish pulse.
    send(32'(NPIX * SAMP), H_HALF);
    repeat (2) @(posedge clock);
    #1;
    check("t6_err_range", 32'(io_err_range), 32'd1);
    for (int i = 80; i < 88; i++) send(32'(i), H_HALF);
    io_rtp_finish = 1'b1;
    @(posedge clock); #1;
    io_rtp_finish = 1'b0;
    n = 0;
    while (!io_done && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("t6_done", 32'(io_done), 32'd1);
    check("t6_in_ready", 32'(io_in_ready), 32'd0);
    acc_before = m_accepts;
    io_in_valid = 1'b1;
    io_ray_id_triangle = 32'd88;
    io_hitT = H_HALF;
    repeat (20) @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    check("done_ignores_input", 32'(m_accepts - acc_before), 32'd0);
    check("done_held", 32'(io_done), 32'd1);
    check("final_pixels_done", io_pixels_done, 32'(m_pushes));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_err_range", 32'(io_err_range), 32'(m_err_range));
    check("final_err_overflow", 32'(io_err_overflow), 32'd0);

    // Reset from DONE returns everything to idle.
    reset = 1'b0;
    #1;
    check("rerst_done", 32'(io_done), 32'd0);
    check("rerst_pixels_done", io_pixels_done, 32'd0);
    check("rerst_err_range", 32'(io_err_range), 32'd0);
    check("rerst_in_ready", 32'(io_in_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ao_result_collector.md
Name: ao_result_collector

Overview:
Sits directly downstream of the TOP_AO ray-traversal core and consumes its per-ray results (io_hitT, io_ray_id_triangle, io_rtp_finish). It classifies each AO ray as occluded or not and accumulates per-pixel occlusion counts in an internal RAM. A pixel is emitted through a valid/ready output FIFO once all SAMPLES rays for it have arrived. Rays may arrive in any order, because the two traversal stacks retire out of order.

Parameters:
NUM_PIXELS, 1024, number of pixels tracked (power of 2)
SAMPLES, 16, AO rays per pixel (power of 2, ≥2)
OUT_DEPTH, 8, output FIFO depth (≥4)
AO_RADIUS, 32'h3F800000, IEEE-754 single; a hit closer than this is an occlusion (1.0)
MISS_HITT, 32'h7F800000, hitT bit pattern meaning "no hit" (+inf)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
io_in_valid  in  1  result valid from traversal core
io_in_ready  out  1  collector can accept a result
io_hitT  in  32  hit distance, float bits
io_ray_id_triangle  in  32  ray id of the result
io_rtp_finish  in  1  core has retired its last ray (level or pulse)
io_out_valid  out  1  pixel result available
io_out_ready  in  1  consumer accepts pixel
io_out_pixel  out  log2(NUM_PIXELS)  pixel index
io_out_occ  out  log2(SAMPLES)+1  occluded sample count, 0..SAMPLES
io_done  out  1  all work drained
io_pixels_done  out  32  pixels emitted so far
io_err_range  out  1  sticky: ray id out of range
io_err_overflow  out  1  sticky: sample arrived for an already-complete pixel

Behaviour:
- While reset is low, all outputs are 0, the FIFO is empty, and the FSM is in CLEAR with clear pointer 0.
- FSM states: CLEAR → RUN → DRAIN → DONE.
- CLEAR: writes {occ=0, cnt=0} to one RAM entry per cycle, NUM_PIXELS cycles in total; io_in_ready=0. It then moves to RUN.
- RUN: io_in_ready=1 when FIFO occupancy + in-flight entries ≤ OUT_DEPTH−1. A result is accepted when valid&ready are both high.
- pixel = ray_id >> log2(SAMPLES).
- If ray_id ≥ NUM_PIXELS*SAMPLES: the result is accepted and discarded, and io_err_range is set.
- Occluded iff hitT != MISS_HITT, hitT[31]==0, and hitT[30:0] < AO_RADIUS[30:0] (unsigned compare). Negative hitT and NaN count as not occluded.
- Pipeline:
  - S0: accept and issue RAM read.
  - S1: synchronous read data returns.
  - S2: cnt+1, occ+occluded; write back.
  - Forwarding: if S1 and S2 target the same pixel, S2's new value replaces the RAM read data. Back-to-back same-pixel results must never lose a count.
- When the new cnt==SAMPLES, S2 pushes {pixel, occ} into the FIFO and writes {0,0} back to the entry, so the entry is reused.
- io_pixels_done increments on each FIFO push and wraps at 2^32.
- If the stored cnt==SAMPLES in S2 (unreachable in normal operation; defensive), it saturates, sets io_err_overflow, and pushes nothing.
- Latency: a completing result accepted at cycle N gives io_out_valid at N+3 when the FIFO was empty.
- FIFO: first-word fall-through. A push and a pop in the same cycle are legal when full or empty.
- The FIFO never overflows, because ready is computed counting the S0–S2 in-flight entries.
- io_rtp_finish seen high in RUN moves the FSM to DRAIN. A result accepted in the same cycle is still processed.
- DRAIN: io_in_ready=0. Move to DONE when the pipeline is empty and the FIFO is empty.
- DONE: io_done=1, held until reset. Inputs are ignored. Incomplete pixels are not emitted.
- Reset asserted mid-operation: the pipeline and FIFO are flushed immediately and the block re-enters CLEAR; RAM contents are rebuilt by CLEAR.

Test Plan:
1. Reset release, then hold io_in_valid=1 → io_in_ready=0 for exactly 1024 cycles, then 1; no output.
2. Ray ids 0..15 in order, hitT alternating 32'h3F000000 (0.5) and 32'h7F800000 → one output {pixel=0, occ=8}, io_pixels_done=1.
3. Ray ids 47,32,33..46 shuffled back-to-back, all hitT=32'h3E800000 (0.25) → {pixel=2, occ=16}; the forwarding path is exercised with no lost count.
4. hitT = 32'h40000000 (2.0), 32'hBF000000 (−0.5), 32'h7FC00000 (NaN) for pixel 3, remaining 13 samples at 0.5 → occ=13.
5. io_out_ready=0 while 10 pixels complete → io_in_ready drops before the FIFO holds 8; after release, 10 pixels emerge in completion order with none lost.
6. ray_id=16384, then io_rtp_finish pulse with pixel 5 half-filled → io_err_range=1; io_done=1 after the FIFO drains; pixel 5 is never emitted.
